rx_backend: RTL and testbench

//  Receive back-end stage of the UART. Consumes the right-aligned raw packets

---
 rtl/rx_backend.sv | 146 ++++++++++++++
 tb/tb_rx_backend.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rx_backend.sv
// UART receive back-end: decodes raw front-end packets (data, parity, stop bits)
// into data/error entries and queues them in a show-ahead FIFO for the register side.
module rx_backend #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cr_ds_i,
  input  logic [1:0]                       cr_p_i,
  input  logic                             cr_s_i,
  input  logic [10:0]                      frame_i,
  input  logic                             frame_valid_i,
  input  logic                             rx_pop_i,
  input  logic                             ovr_clr_i,
  output logic [7:0]                       rx_data_o,
  output logic                             rx_pe_o,
  output logic                             rx_fe_o,
  output logic                             rx_valid_o,
  output logic                             rx_full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count_o,
  output logic                             ovr_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } entry_t;

  // Decode stage signals
  logic [3:0] data_len;
  logic [3:0] stop_pos;
  logic       par_en;
  logic       par_odd;
  logic       par_bit;
  entry_t     dec_entry;

  entry_t     dec_entry_q;
  logic       dec_valid_q;

  // FIFO state
  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d;
  entry_t          hold_q, hold_d;

  logic   is_full;
  logic   is_empty;
  logic   push_en;
  logic   pop_en;
  logic   drop;
  entry_t shown;

  // Field positions move with data size and parity enable; the stop bits follow
  // whatever precedes them, so their index is computed rather than fixed.
  always_comb begin
    data_len       = 4'd7 + {3'd0, cr_ds_i};
    par_en         = (cr_p_i != 2'b00);
    par_odd        = (cr_p_i == 2'b10);
    dec_entry      = '0;
    dec_entry.data = cr_ds_i ? frame_i[7:0] : {1'b0, frame_i[6:0]};
    par_bit        = frame_i[data_len];
    stop_pos       = data_len + {3'd0, par_en};
    dec_entry.pe   = par_en && ((^dec_entry.data ^ par_bit) != par_odd);
    dec_entry.fe   = !frame_i[stop_pos] || (cr_s_i && !frame_i[stop_pos + 4'd1]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_q <= 1'b0;
      dec_entry_q <= '0;
    end else begin
      dec_valid_q <= frame_valid_i;
      if (frame_valid_i) begin
        dec_entry_q <= dec_entry;
      end
    end
  end

  // A write into a full FIFO is still accepted when the head is popped at the same edge.
  always_comb begin
    is_full  = (count_q == DEPTH_C);
    is_empty = (count_q == '0);
    pop_en   = rx_pop_i && !is_empty;
    push_en  = dec_valid_q && (!is_full || rx_pop_i);
    drop     = dec_valid_q && is_full && !rx_pop_i;

    wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end

    shown  = is_empty ? hold_q : mem_q[rd_ptr_q];
    hold_d = shown;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      hold_q   <= hold_d;
    end
  end

  // Storage is only ever read while the slot is occupied, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= dec_entry_q;
    end
  end

  assign rx_data_o  = shown.data;
  assign rx_pe_o    = shown.pe;
  assign rx_fe_o    = shown.fe;
  assign rx_valid_o = !is_empty;
  assign rx_full_o  = is_full;
  assign rx_count_o = count_q;
  assign ovr_o      = ovr_q;

endmodule

// File: tb/tb_rx_backend.sv
// Directed bench for rx_backend: decode cases, latency, overflow, full+pop,
// empty pop and asynchronous reset during activity.
module tb_rx_backend;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic [10:0] frame_i;
  logic        frame_valid_i;
  logic        rx_pop_i;
  logic        ovr_clr_i;
  logic [7:0]  rx_data_o;
  logic        rx_pe_o;
  logic        rx_fe_o;
  logic        rx_valid_o;
  logic        rx_full_o;
  logic [2:0]  rx_count_o;
  logic        ovr_o;

  int compared   = 0;
  int mismatched = 0;

  rx_backend #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cr_ds_i       (cr_ds_i),
    .cr_p_i        (cr_p_i),
    .cr_s_i        (cr_s_i),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .rx_pop_i      (rx_pop_i),
    .ovr_clr_i     (ovr_clr_i),
    .rx_data_o     (rx_data_o),
    .rx_pe_o       (rx_pe_o),
    .rx_fe_o       (rx_fe_o),
    .rx_valid_o    (rx_valid_o),
    .rx_full_o     (rx_full_o),
    .rx_count_o    (rx_count_o),
    .ovr_o         (ovr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setConfig(input logic ds, input logic [1:0] p, input logic s);
    cr_ds_i = ds;
    cr_p_i  = p;
    cr_s_i  = s;
  endtask

  // One-cycle frame strobe; returns 1ns after the sampling edge.
  task automatic applyStimulus(input logic [10:0] frame);
    frame_i       = frame;
    frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
  endtask

  task automatic popOne();
    rx_pop_i = 1'b1;
    tick();
    rx_pop_i = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [7:0] data,
                           input logic pe, input logic fe);
    checkOutput({tag, "_data"}, {24'd0, rx_data_o}, {24'd0, data});
    checkOutput({tag, "_pe"}, {31'd0, rx_pe_o}, {31'd0, pe});
    checkOutput({tag, "_fe"}, {31'd0, rx_fe_o}, {31'd0, fe});
  endtask

  initial begin
    rst_ni        = 1'b0;
    frame_i       = '0;
    frame_valid_i = 1'b0;
    rx_pop_i      = 1'b0;
    ovr_clr_i     = 1'b0;
    setConfig(1'b1, 2'b00, 1'b0);
    #23;
    checkOutput("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("rst_count", {29'd0, rx_count_o}, 32'd0);
    checkOutput("rst_ovr", {31'd0, ovr_o}, 32'd0);
    checkHead("rst", 8'h00, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();

    // 8N1 clean frame, with latency check
    applyStimulus(11'h1A5);
    checkOutput("t1_valid_n1", {31'd0, rx_valid_o}, 32'd0);
    tick();
    checkOutput("t1_valid_n2", {31'd0, rx_valid_o}, 32'd1);
    checkOutput("t1_count", {29'd0, rx_count_o}, 32'd1);
    checkHead("t1", 8'hA5, 1'b0, 1'b0);
    popOne();
    checkOutput("t1_count_pop", {29'd0, rx_count_o}, 32'd0);
    checkHead("t1_hold", 8'hA5, 1'b0, 1'b0);

    // 7E1 with wrong parity bit
    setConfig(1'b0, 2'b01, 1'b0);
    applyStimulus(11'h1D5);
    tick();
    checkHead("t2", 8'h55, 1'b1, 1'b0);
    popOne();

    // 8O2 with second stop bit low
    setConfig(1'b1, 2'b10, 1'b1);
    applyStimulus(11'h300);
    tick();
    checkHead("t3", 8'h00, 1'b0, 1'b1);
    popOne();

    // Overflow: five back-to-back 8N1 frames
    setConfig(1'b1, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(11'h100 | 11'(i));
    checkOutput("t4_count_pre", {29'd0, rx_count_o}, 32'd4);
    checkOutput("t4_ovr_pre", {31'd0, ovr_o}, 32'd0);
    tick();
    checkOutput("t4_count", {29'd0, rx_count_o}, 32'd4);
    checkOutput("t4_full", {31'd0, rx_full_o}, 32'd1);
    checkOutput("t4_ovr", {31'd0, ovr_o}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("t4_pop_data", {24'd0, rx_data_o}, i);
      popOne();
    end
    checkOutput("t4_empty", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("t4_ovr_sticky", {31'd0, ovr_o}, 32'd1);
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    checkOutput("t4_ovr_clr", {31'd0, ovr_o}, 32'd0);

    // Full FIFO with pop at the write edge
    for (int i = 0; i < 4; i++) applyStimulus(11'h111 + 11'(i));
    tick();
    checkOutput("t5_count_full", {29'd0, rx_count_o}, 32'd4);
    applyStimulus(11'h115);
    rx_pop_i = 1'b1;
    tick();
    rx_pop_i = 1'b0;
    checkOutput("t5_count", {29'd0, rx_count_o}, 32'd4);
    checkOutput("t5_ovr", {31'd0, ovr_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_pop_data", {24'd0, rx_data_o}, 32'h12 + i);
      popOne();
    end
    checkOutput("t5_count_empty", {29'd0, rx_count_o}, 32'd0);
    popOne();
    checkOutput("t5_pop_empty", {29'd0, rx_count_o}, 32'd0);
    checkOutput("t5_valid_empty", {31'd0, rx_valid_o}, 32'd0);

    // Reset while two entries are stored, overrun is set and decode is busy
    for (int i = 0; i < 5; i++) applyStimulus(11'h120 + 11'(i));
    tick();
    checkOutput("t6_ovr_set", {31'd0, ovr_o}, 32'd1);
    popOne();
    popOne();
    checkOutput("t6_count_pre", {29'd0, rx_count_o}, 32'd2);
    applyStimulus(11'h1EE);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_count", {29'd0, rx_count_o}, 32'd0);
    checkOutput("t6_valid", {31'd0, rx_valid_o}, 32'd0);
    checkOutput("t6_ovr", {31'd0, ovr_o}, 32'd0);
    checkHead("t6", 8'h00, 1'b0, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t6_post_count", {29'd0, rx_count_o}, 32'd0);
    checkOutput("t6_post_valid", {31'd0, rx_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
